// File: rtl/meas_scan_pkg.sv
// Shared constants and FSM encoding for the measurement scan sequencer.
package meas_scan_pkg;
    localparam int CH_W_DEF     = 6;
    localparam int ADC_W_DEF    = 12;
    localparam int MAX_AVG_DEF  = 4;
    localparam int SETTLE_W_DEF = 16;
    localparam int RES_W        = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SEL    = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CONV   = 3'd3;
    localparam logic [2:0] ST_ACC    = 3'd4;
    localparam logic [2:0] ST_STORE  = 3'd5;
    localparam logic [2:0] ST_FIN    = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        SEL    = ST_SEL,
        SETTLE = ST_SETTLE,
        CONV   = ST_CONV,
        ACC    = ST_ACC,
        STORE  = ST_STORE,
        FIN    = ST_FIN
    } state_t;

    function automatic logic [2:0] clamp_avg(input logic [2:0] n, input int max_avg);
        return (int'(n) > max_avg) ? 3'(max_avg) : n;
    endfunction
endpackage

// File: rtl/meas_scan_acc.sv
// Per-channel sample accumulator: sums 2^navg_eff samples and normalises by shifting.
module meas_scan_acc
    import meas_scan_pkg::*;
#(
    parameter int ADC_W   = ADC_W_DEF,
    parameter int MAX_AVG = MAX_AVG_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add,
    input  logic [ADC_W-1:0] sample,
    input  logic [2:0]       navg_eff,
    output logic             last,
    output logic [RES_W-1:0] result
);
    localparam int ACC_W = ADC_W + MAX_AVG;
    localparam int CNT_W = MAX_AVG + 1;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] shifted;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] target;

    // last is true while the sample being added is the final one of the channel
    assign target  = (CNT_W'(1) << navg_eff) - CNT_W'(1);
    assign last    = (cnt == target);
    assign shifted = acc >> navg_eff;
    assign result  = RES_W'(shifted);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (add) begin
            acc <= acc + ACC_W'(sample);
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/meas_scan_seq.sv
// Scan sequencer: steps the mux over a channel range, settles, converts and stores one result per channel.
// Averaging is built only when MEAS_SCAN_SEQ_AVG_EN is defined; otherwise one conversion per channel.
module meas_scan_seq
    import meas_scan_pkg::*;
#(
    parameter int CH_W     = CH_W_DEF,
    parameter int ADC_W    = ADC_W_DEF,
    parameter int MAX_AVG  = MAX_AVG_DEF,
    parameter int SETTLE_W = SETTLE_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [CH_W-1:0]     ch_first,
    input  logic [CH_W-1:0]     ch_last,
    input  logic [SETTLE_W-1:0] settle_cyc,
    input  logic [2:0]          navg,
    output logic [CH_W-1:0]     mux_ch,
    output logic                mux_en,
    output logic                adc_req,
    input  logic                adc_ack,
    input  logic [ADC_W-1:0]    adc_data,
    output logic                res_wr,
    output logic [CH_W-1:0]     res_addr,
    output logic [RES_W-1:0]    res_data,
    output logic                busy,
    output logic                done,
    output logic                err
);
    state_t              state;
    logic [CH_W-1:0]     ch;
    logic [CH_W-1:0]     last_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [ADC_W-1:0]    sample;
    logic                last_sample;
    logic                unused_navg;

    assign unused_navg = ^clamp_avg(navg, MAX_AVG);

`ifdef MEAS_SCAN_SEQ_AVG_EN
    logic [2:0] navg_q;

    always_ff @(posedge clk) begin
        if (rst)
            navg_q <= '0;
        else if (state == IDLE && start && !abort)
            navg_q <= clamp_avg(navg, MAX_AVG);
    end

    meas_scan_acc #(.ADC_W(ADC_W), .MAX_AVG(MAX_AVG)) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (abort || state == STORE),
        .add      (state == ACC),
        .sample   (sample),
        .navg_eff (navg_q),
        .last     (last_sample),
        .result   (res_data)
    );
`else
    assign last_sample = 1'b1;
    assign res_data    = RES_W'(sample);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ch         <= '0;
            last_q     <= '0;
            settle_q   <= '0;
            settle_cnt <= '0;
            sample     <= '0;
            mux_ch     <= '0;
            mux_en     <= 1'b0;
            adc_req    <= 1'b0;
            res_wr     <= 1'b0;
            res_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done   <= 1'b0;
            res_wr <= 1'b0;
            // abort outranks everything, including a start arriving in IDLE
            if (abort && state != IDLE) begin
                state   <= IDLE;
                busy    <= 1'b0;
                mux_en  <= 1'b0;
                adc_req <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && !abort) begin
                        last_q   <= ch_last;
                        settle_q <= settle_cyc;
                        ch       <= ch_first;
                        if (ch_first > ch_last) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            err    <= 1'b0;
                            busy   <= 1'b1;
                            mux_en <= 1'b1;
                            mux_ch <= ch_first;
                            state  <= SEL;
                        end
                    end
                    SEL: if (settle_q == '0) begin
                        adc_req <= 1'b1;
                        state   <= CONV;
                    end else begin
                        settle_cnt <= settle_q;
                        state      <= SETTLE;
                    end
                    SETTLE: if (settle_cnt == SETTLE_W'(1)) begin
                        adc_req <= 1'b1;
                        state   <= CONV;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                    CONV: if (adc_ack) begin
                        sample  <= adc_data;
                        adc_req <= 1'b0;
                        state   <= ACC;
                    end
                    ACC: if (last_sample) begin
                        res_wr   <= 1'b1;
                        res_addr <= ch;
                        state    <= STORE;
                    end else begin
                        adc_req <= 1'b1;
                        state   <= CONV;
                    end
                    // equality stop means ch_last at the top of the range never wraps
                    STORE: if (ch == last_q) begin
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        mux_en <= 1'b0;
                        state  <= FIN;
                    end else begin
                        ch     <= ch + 1'b1;
                        mux_ch <= ch + 1'b1;
                        state  <= SEL;
                    end
                    FIN:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_meas_scan_seq.sv
// Randomised bench for meas_scan_seq with an ADC responder and a per-channel averaging model.
module tb_meas_scan_seq;
    localparam int CH_W = 6, ADC_W = 12, MAX_AVG = 4, SETTLE_W = 16;
`ifdef MEAS_SCAN_SEQ_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif

    logic clk, rst, start, abort, adc_ack;
    logic [CH_W-1:0] ch_first, ch_last, mux_ch, res_addr;
    logic [SETTLE_W-1:0] settle_cyc;
    logic [2:0] navg;
    logic [ADC_W-1:0] adc_data;
    logic [15:0] res_data;
    logic mux_en, adc_req, res_wr, busy, done, err;

    meas_scan_seq #(.CH_W(CH_W), .ADC_W(ADC_W), .MAX_AVG(MAX_AVG), .SETTLE_W(SETTLE_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_first(ch_first), .ch_last(ch_last),
        .settle_cyc(settle_cyc), .navg(navg), .mux_ch(mux_ch), .mux_en(mux_en), .adc_req(adc_req),
        .adc_ack(adc_ack), .adc_data(adc_data), .res_wr(res_wr), .res_addr(res_addr),
        .res_data(res_data), .busy(busy), .done(done), .err(err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    // monitor-owned logs
    int cyc = 0, done_cnt = 0, done_cyc = 0, req_cnt = 0, busy_cnt = 0, sel_at = -1;
    int wr_addr[$], wr_data[$], wr_cyc[$], gap[$];
    logic pe = 1'b0;
    logic [CH_W-1:0] pc = '0;
    // responder-owned
    int sent[$];
    int w_left = 0;
    bit req_seen = 1'b0;
    // test-owned
    int fixed_q[$];
    int ack_wait_cfg = -1;
    bit stray_req = 1'b0;
    int wr0, s0, dn0, rq0, bz0, g0, start_cyc;
    int exp_addr[$], exp_data[$];

    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (res_wr) begin
                wr_addr.push_back(int'(res_addr)); wr_data.push_back(int'(res_data)); wr_cyc.push_back(cyc);
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (adc_req) req_cnt++;
            if (busy) busy_cnt++;
            if (mux_en && (!pe || mux_ch != pc)) sel_at = cyc;
            if (adc_req && sel_at >= 0) begin gap.push_back(cyc - sel_at); sel_at = -1; end
            pe = mux_en; pc = mux_ch;
        end
    end

    initial begin : responder
        int v;
        adc_ack = 1'b0; adc_data = '0;
        forever begin
            @(negedge clk);
            if (adc_ack) adc_ack = 1'b0;
            else if (adc_req) begin
                if (!req_seen) begin
                    req_seen = 1'b1;
                    w_left = (ack_wait_cfg < 0) ? int'($urandom_range(0, 3)) : ack_wait_cfg;
                end
                if (w_left == 0) begin
                    v = (fixed_q.size() != 0) ? fixed_q.pop_front() : int'($urandom_range(0, 4095));
                    adc_data = ADC_W'(v); adc_ack = 1'b1; sent.push_back(v); req_seen = 1'b0;
                end else w_left--;
            end else begin
                req_seen = 1'b0;
                if (stray_req) begin adc_ack = 1'b1; adc_data = '1; stray_req = 1'b0; end
            end
        end
    end

    task automatic step(); @(negedge clk); #1; endtask

    function automatic int navg_eff(int n);
        return AVG_EN ? ((n > MAX_AVG) ? MAX_AVG : n) : 0;
    endfunction

    // Expected writes: channel c gets the floor mean of the next 2^navg_eff samples handed out.
    task automatic expect_writes(input int first, input int last, input int nv);
        int n, k, s;
        n = 1 << navg_eff(nv); k = s0;
        exp_addr.delete(); exp_data.delete();
        for (int c = first; c <= last; c++) begin
            s = 0;
            for (int j = 0; j < n; j++) begin s += (k < sent.size()) ? sent[k] : 0; k++; end
            exp_addr.push_back(c); exp_data.push_back(s >> navg_eff(nv));
        end
    endtask

    task automatic scan(input int first, input int last, input int settle, input int nv);
        wr0 = wr_addr.size(); s0 = sent.size(); dn0 = done_cnt; rq0 = req_cnt; bz0 = busy_cnt; g0 = gap.size();
        ch_first = CH_W'(first); ch_last = CH_W'(last); settle_cyc = SETTLE_W'(settle); navg = 3'(nv);
        start = 1'b1; start_cyc = cyc; step(); start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            if (done_cnt != dn0) ok = 1'b1; else step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; ch_first = '0; ch_last = '0; settle_cyc = '0; navg = '0;
        repeat (3) step();
        n_cmp++; if ({mux_ch, mux_en, adc_req} !== '0) begin n_bad++; $display("FAIL reset_mux got %0h want 0", {mux_ch, mux_en, adc_req}); end
        n_cmp++; if ({res_wr, res_addr, res_data} !== '0) begin n_bad++; $display("FAIL reset_res got %0h want 0", {res_wr, res_addr, res_data}); end
        n_cmp++; if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL reset_status got %b want 000", {busy, done, err}); end
        rst = 1'b0; step();
    endtask

    task automatic test_single();
        bit ok;
        ack_wait_cfg = 2; fixed_q.delete(); fixed_q.push_back(12'hABC);
        scan(5, 5, 0, 0); wait_done(200, ok); step();
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_done got timeout want done"); end
        n_cmp++; if (wr_addr.size() - wr0 != 1) begin n_bad++; $display("FAIL single_wr_count got %0d want 1", wr_addr.size() - wr0); end
        else begin
            n_cmp++; if (wr_addr[wr0] != 5 || wr_data[wr0] != 16'h0ABC) begin n_bad++; $display("FAIL single_wr got %0d/%0h want 5/0abc", wr_addr[wr0], wr_data[wr0]); end
            n_cmp++; if (done_cyc - wr_cyc[wr0] != 1) begin n_bad++; $display("FAIL single_done_lat got %0d want 1", done_cyc - wr_cyc[wr0]); end
        end
        n_cmp++; if (sent.size() - s0 != 1) begin n_bad++; $display("FAIL single_acks got %0d want 1", sent.size() - s0); end
    endtask

    task automatic test_range_avg();
        bit ok;
        ack_wait_cfg = -1; fixed_q.delete();
        repeat (3) for (int i = 0; i < 4; i++) fixed_q.push_back(100 + i);
        scan(2, 4, 10, 2); wait_done(1000, ok); step(); fixed_q.delete();
        expect_writes(2, 4, 2);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL range_done got timeout want done"); end
        n_cmp++; if (wr_addr.size() - wr0 != 3) begin n_bad++; $display("FAIL range_wr_count got %0d want 3", wr_addr.size() - wr0); end
        else for (int i = 0; i < 3; i++) begin
            n_cmp++; if (wr_addr[wr0+i] != exp_addr[i] || wr_data[wr0+i] != exp_data[i]) begin
                n_bad++; $display("FAIL range_wr%0d got %0d/%0d want %0d/%0d", i, wr_addr[wr0+i], wr_data[wr0+i], exp_addr[i], exp_data[i]); end
        end
        n_cmp++; if (gap.size() - g0 != 3) begin n_bad++; $display("FAIL range_gap_count got %0d want 3", gap.size() - g0); end
        else for (int i = 0; i < 3; i++) begin
            n_cmp++; if (gap[g0+i] != 11) begin n_bad++; $display("FAIL range_settle%0d got %0d want 11", i, gap[g0+i]); end
        end
        n_cmp++; if (sent.size() - s0 != 3 * (1 << navg_eff(2))) begin n_bad++; $display("FAIL range_acks got %0d want %0d", sent.size() - s0, 3 * (1 << navg_eff(2))); end
    endtask

    task automatic test_range_err();
        scan(7, 3, 0, 0); repeat (5) step();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rerr_err got %b want 1", err); end
        n_cmp++; if (done_cnt - dn0 != 1 || done_cyc != start_cyc + 1) begin n_bad++; $display("FAIL rerr_done got %0d@%0d want 1@%0d", done_cnt - dn0, done_cyc, start_cyc + 1); end
        n_cmp++; if (req_cnt != rq0 || busy_cnt != bz0 || wr_addr.size() != wr0) begin
            n_bad++; $display("FAIL rerr_quiet got req %0d busy %0d wr %0d want 0 0 0", req_cnt - rq0, busy_cnt - bz0, wr_addr.size() - wr0); end
    endtask

    task automatic test_abort();
        bit hit = 1'b0;
        ack_wait_cfg = 3;
        scan(0, 3, 2, 1);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL abort_err_clr got %b want 0", err); end
        for (int i = 0; i < 300 && !hit; i++) begin if (mux_ch == 1 && adc_req) hit = 1'b1; else step(); end
        abort = 1'b1; step(); abort = 1'b0;
        n_cmp++; if (!hit || {busy, mux_en, adc_req} !== 3'b000) begin n_bad++; $display("FAIL abort_outputs got hit %b %b want 1 000", hit, {busy, mux_en, adc_req}); end
        repeat (20) step();
        expect_writes(0, 0, 1);
        n_cmp++; if (done_cnt != dn0) begin n_bad++; $display("FAIL abort_done got %0d want 0", done_cnt - dn0); end
        n_cmp++; if (wr_addr.size() - wr0 != 1 || wr_addr[wr0] != 0 || wr_data[wr0] != exp_data[0]) begin
            n_bad++; $display("FAIL abort_wr got n%0d %0d/%0d want n1 0/%0d", wr_addr.size() - wr0, wr_addr[wr0], wr_data[wr0], exp_data[0]); end
        ack_wait_cfg = -1;
    endtask

    task automatic test_start_busy();
        bit ok;
        scan(1, 3, 1, 0); repeat (3) step();
        ch_first = 10; ch_last = 12; settle_cyc = 0; navg = 7; start = 1'b1; step(); start = 1'b0;
        wait_done(1000, ok); step();
        expect_writes(1, 3, 0);
        n_cmp++; if (!ok || done_cnt - dn0 != 1) begin n_bad++; $display("FAIL busy_done got %0d want 1", done_cnt - dn0); end
        n_cmp++; if (wr_addr.size() - wr0 != 3) begin n_bad++; $display("FAIL busy_wr_count got %0d want 3", wr_addr.size() - wr0); end
        else for (int i = 0; i < 3; i++) begin
            n_cmp++; if (wr_addr[wr0+i] != exp_addr[i] || wr_data[wr0+i] != exp_data[i]) begin
                n_bad++; $display("FAIL busy_wr%0d got %0d/%0d want %0d/%0d", i, wr_addr[wr0+i], wr_data[wr0+i], exp_addr[i], exp_data[i]); end
        end
    endtask

    task automatic test_navg_clamp();
        bit ok;
        scan(0, 1, 0, 7); wait_done(2000, ok); step();
        expect_writes(0, 1, 7);
        n_cmp++; if (!ok || sent.size() - s0 != 2 * (1 << navg_eff(7))) begin n_bad++; $display("FAIL clamp_acks got %0d want %0d", sent.size() - s0, 2 * (1 << navg_eff(7))); end
        n_cmp++; if (wr_addr.size() - wr0 != 2) begin n_bad++; $display("FAIL clamp_wr_count got %0d want 2", wr_addr.size() - wr0); end
        else for (int i = 0; i < 2; i++) begin
            n_cmp++; if (wr_addr[wr0+i] != exp_addr[i] || wr_data[wr0+i] != exp_data[i]) begin
                n_bad++; $display("FAIL clamp_wr%0d got %0d/%0d want %0d/%0d", i, wr_addr[wr0+i], wr_data[wr0+i], exp_addr[i], exp_data[i]); end
        end
    endtask

    task automatic test_ack_outside();
        bit ok;
        scan(3, 3, 8, 0); repeat (3) step(); stray_req = 1'b1;
        wait_done(500, ok); step();
        expect_writes(3, 3, 0);
        n_cmp++; if (!ok || sent.size() - s0 != 1) begin n_bad++; $display("FAIL stray_acks got %0d want 1", sent.size() - s0); end
        n_cmp++; if (wr_addr.size() - wr0 != 1 || wr_data[wr0] != exp_data[0]) begin
            n_bad++; $display("FAIL stray_wr got n%0d %0d want n1 %0d", wr_addr.size() - wr0, wr_data[wr0], exp_data[0]); end
    endtask

    task automatic test_top_channel();
        bit ok;
        scan(62, 63, 0, 0); wait_done(500, ok); step();
        n_cmp++; if (!ok || wr_addr.size() - wr0 != 2) begin n_bad++; $display("FAIL top_wr_count got %0d want 2", wr_addr.size() - wr0); end
        else begin
            n_cmp++; if (wr_addr[wr0] != 62 || wr_addr[wr0+1] != 63) begin n_bad++; $display("FAIL top_addr got %0d,%0d want 62,63", wr_addr[wr0], wr_addr[wr0+1]); end
        end
        n_cmp++; if (mux_ch !== 6'd63 || busy !== 1'b0 || mux_en !== 1'b0) begin n_bad++; $display("FAIL top_hold got ch %0d busy %b en %b want 63 0 0", mux_ch, busy, mux_en); end
    endtask

    task automatic test_random();
        bit ok;
        int f, l, st, nv;
        for (int it = 0; it < 6; it++) begin
            f = $urandom_range(0, 60); l = f + $urandom_range(0, 3); st = $urandom_range(0, 4); nv = $urandom_range(0, 7);
            scan(f, l, st, nv); wait_done(3000, ok); step();
            expect_writes(f, l, nv);
            n_cmp++; if (!ok || wr_addr.size() - wr0 != exp_addr.size()) begin
                n_bad++; $display("FAIL rand%0d_count got %0d want %0d", it, wr_addr.size() - wr0, exp_addr.size()); end
            else for (int i = 0; i < exp_addr.size(); i++) begin
                n_cmp++; if (wr_addr[wr0+i] != exp_addr[i] || wr_data[wr0+i] != exp_data[i]) begin
                    n_bad++; $display("FAIL rand%0d_wr%0d got %0d/%0d want %0d/%0d", it, i, wr_addr[wr0+i], wr_data[wr0+i], exp_addr[i], exp_data[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int wr_at;
        scan(0, 2, 3, 0); repeat (8) step();
        rst = 1'b1; step(); rst = 1'b0; wr_at = wr_addr.size();
        n_cmp++; if ({busy, mux_en, adc_req, res_wr, done, err, mux_ch, res_addr, res_data} !== '0) begin
            n_bad++; $display("FAIL rstmid_outputs got %0h want 0", {busy, mux_en, adc_req, res_wr, done, err, mux_ch, res_addr, res_data}); end
        repeat (30) step();
        n_cmp++; if (done_cnt != dn0 || wr_addr.size() != wr_at) begin n_bad++; $display("FAIL rstmid_quiet got done %0d wr %0d want 0 0", done_cnt - dn0, wr_addr.size() - wr_at); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_range_avg();
        test_range_err();
        test_abort();
        test_start_busy();
        test_navg_clamp();
        test_ack_outside();
        test_top_channel();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
